cpu_step_ctrl: RTL and testbench
================================

// Module: cpu_step_ctrl
// PURPOSE
//  Synthesizable run/step controller for the RISC-V core; replaces the raw CLK_BUTT stepping input.
//  Debounces a push-button and produces a one-cycle step enable for the core.
//  Modes: free-run, single-step, N-step burst and halt.
//  Captures the core's result bus into an NUM_CH-deep history for board display.
// PARAMETERS
//  DATA_W          16  width of result bus / history entries
//  DEBOUNCE_CYCLES 4   consecutive stable cycles required to accept a button level (>=1)
//  BURST_W         8   width of burst length / remaining-step counter
//  NUM_CH          4   history depth (>=2)
//  CNT_W           32  step counter width (STEP_TRACE_EN only)
// PORTS
//  clk        in   1                    system clock
//  reset      in   1                    async, active-low; all state cleared while 0
//  btn_raw    in   1                    asynchronous push-button, active-high
//  mode       in   2                    00 FREE, 01 SINGLE, 10 BURST, 11 HALT
//  burst_len  in   BURST_W              steps per BURST press; sampled at the press
//  result_in  in   DATA_W               core result bus
//  ch_sel     in   $clog2(NUM_CH)       history entry select
//  step_en    out  1                    core clock-enable; one pulse = one step
//  busy       out  1                    1 when FSM != IDLE
//  result_out out  DATA_W               hist[ch_sel], combinational read
//  step_cnt   out  CNT_W                only with STEP_TRACE_EN
// BEHAVIOUR
//  Reset: step_en=0, busy=0, all hist=0, result_out=0, step_cnt=0.
//   Sync/debounce flops=0, FSM=IDLE. Applies immediately and asynchronously, also mid-burst/run.
//  Input sync: 2-FF synchroniser on btn_raw.
//   btn_clean changes only after DEBOUNCE_CYCLES consecutive equal synced samples.
//  press: registered 1-cycle pulse on btn_clean 0->1.
//   Latency: btn_raw high from edge k -> press at k+2+DEBOUNCE_CYCLES -> step_en at k+3+DEBOUNCE_CYCLES.
//  FSM states: IDLE, RUN, SNGL, BURST. step_en is registered, high exactly in RUN/SNGL/BURST cycles.
//   IDLE: mode==FREE -> RUN.
//    mode==SINGLE & press -> SNGL.
//    mode==BURST & press & burst_len!=0 -> BURST, rem<=burst_len.
//    burst_len==0 press ignored. HALT: stay.
//   RUN:  step_en every cycle; mode!=FREE -> IDLE (step_en 0 next cycle).
//   SNGL: one step_en cycle -> IDLE unconditionally.
//   BURST: step_en each cycle, rem decrements.
//    rem==1 -> IDLE (exactly burst_len pulses).
//    mode==HALT aborts -> IDLE next cycle.
//    Other mode changes do not abort.
//  Presses arriving while not IDLE are dropped, not queued.
//  History: on each clk edge with step_en==1: hist[0]<=result_in, hist[i]<=hist[i-1].
//   Otherwise hold. ch_sel>=NUM_CH -> result_out=0.
//  Button held continuously yields one press only; release must pass debounce before the next press.
// CONFIGURATION
//  STEP_TRACE_EN defined:
//   step_cnt port present; increments on every step_en cycle.
//   Wraps all-ones -> 0; reset to 0.
//  STEP_TRACE_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package cpu_step_pkg:
//   mode_e {MODE_FREE, MODE_SINGLE, MODE_BURST, MODE_HALT}
//   state_e {ST_IDLE, ST_RUN, ST_SNGL, ST_BURST}
//  Sub-module btn_debounce (#DEBOUNCE_CYCLES):
//   contains the synchroniser, debounce counter and press pulse.
//   Ports clk, reset, btn_raw, press.
//  Top holds the FSM, burst counter, history shift register and optional trace counter.
// TESTING (DEBOUNCE_CYCLES=4, NUM_CH=4, DATA_W=16)
//  1 Reset: reset=0 5 cycles, btn_raw=1, mode=FREE -> step_en=0, busy=0, result_out=0; release -> RUN.
//  2 Single: mode=01, btn_raw high 10 cycles from edge k, result_in=16'hA5A5.
//    -> one step_en pulse at k+7 only; hist[0]=A5A5.
//  3 Bounce: mode=01, btn_raw toggles every 2 cycles for 12 cycles then low -> no step_en, busy stays 0.
//  4 Burst: mode=10, burst_len=5, press, result_in=1,2,3,4,5 on successive steps.
//    -> 5 consecutive step_en, busy high 5 cycles.
//    -> ch_sel 0..3 read 5,4,3,2.
//  5 Abort: burst_len=200, mode->11 after 10 pulses -> step_en 0 next cycle, busy 0.
//    -> step_cnt=10 (STEP_TRACE_EN).
//    -> second press during burst had no effect.
//  6 Free-run + reset: mode=00 20 cycles -> 20 pulses.
//    -> reset low mid-run: step_en, busy, hist cleared without waiting for clk.

Source files
------------

// File: rtl/cpu_step_pkg.sv
// Shared types for the run/step controller: operating modes and FSM states.
package cpu_step_pkg;

  typedef enum logic [1:0] {
    MODE_FREE   = 2'b00,
    MODE_SINGLE = 2'b01,
    MODE_BURST  = 2'b10,
    MODE_HALT   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_SNGL  = 2'b10,
    ST_BURST = 2'b11
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: 2-FF synchroniser, stable-level debounce and a
// registered one-cycle pulse on each accepted 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clean_q, clean_d;
  logic          clean_prev_q;
  logic          press_q;

  // The level only flips after DEBOUNCE_CYCLES consecutive samples that disagree with it.
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    if (sync_q[1] != clean_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) clean_d = sync_q[1];
      else                                   cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      clean_q      <= 1'b0;
      clean_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], btn_raw};
      cnt_q        <= cnt_d;
      clean_q      <= clean_d;
      clean_prev_q <= clean_q;
      press_q      <= clean_q & ~clean_prev_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/step controller: debounced button drives FREE/SINGLE/BURST/HALT stepping
// of the core and keeps a result history. Optional STEP_TRACE_EN adds step_cnt.
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int DATA_W          = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BURST_W         = 8,
  parameter int NUM_CH          = 4
`ifdef STEP_TRACE_EN
  ,parameter int CNT_W          = 32
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      btn_raw,
  input  logic [1:0]                mode,
  input  logic [BURST_W-1:0]        burst_len,
  input  logic [DATA_W-1:0]         result_in,
  input  logic [$clog2(NUM_CH)-1:0] ch_sel,
  output logic                      step_en,
  output logic                      busy,
  output logic [DATA_W-1:0]         result_out
`ifdef STEP_TRACE_EN
  ,output logic [CNT_W-1:0]         step_cnt
`endif
);

  logic                          press;
  mode_e                         mode_m;
  state_e                        state_q, state_d;
  logic [BURST_W-1:0]            rem_q, rem_d;
  logic                          step_en_q;
  logic [NUM_CH-1:0][DATA_W-1:0] hist_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_raw),
    .press   (press)
  );

  assign mode_m = mode_e'(mode);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mode_m == MODE_FREE) state_d = ST_RUN;
        else if (mode_m == MODE_SINGLE && press) state_d = ST_SNGL;
        else if (mode_m == MODE_BURST && press && burst_len != '0) begin
          state_d = ST_BURST;
          rem_d   = burst_len;
        end
      end
      ST_RUN:  if (mode_m != MODE_FREE) state_d = ST_IDLE;
      ST_SNGL: state_d = ST_IDLE;
      ST_BURST: begin
        // Only HALT aborts a burst; other mode changes let it finish.
        rem_d = rem_q - BURST_W'(1);
        if (rem_q == BURST_W'(1) || mode_m == MODE_HALT) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      step_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      step_en_q <= (state_d != ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         hist_q <= '0;
    else if (step_en_q) hist_q <= {hist_q[NUM_CH-2:0], result_in};
  end

  always_comb begin
    result_out = '0;
    if (int'(ch_sel) < NUM_CH) result_out = hist_q[ch_sel];
  end

  assign step_en = step_en_q;
  assign busy    = (state_q != ST_IDLE);

`ifdef STEP_TRACE_EN
  logic [CNT_W-1:0] step_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         step_cnt_q <= '0;
    else if (step_en_q) step_cnt_q <= step_cnt_q + CNT_W'(1);
  end

  assign step_cnt = step_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DEBOUNCE_CYCLES=4, NUM_CH=4, DATA_W=16.
module tb_cpu_step_ctrl;

  localparam int DATA_W  = 16;
  localparam int DB      = 4;
  localparam int BURST_W = 8;
  localparam int NUM_CH  = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               btn_raw = 1'b0;
  logic [1:0]         mode = 2'b11;
  logic [BURST_W-1:0] burst_len = '0;
  logic [DATA_W-1:0]  result_in = '0;
  logic [1:0]         ch_sel = '0;
  logic               step_en, busy;
  logic [DATA_W-1:0]  result_out;
`ifdef STEP_TRACE_EN
  logic [31:0]        step_cnt;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int pulses, busy_cnt, first, i;

  cpu_step_ctrl #(
    .DATA_W(DATA_W), .DEBOUNCE_CYCLES(DB), .BURST_W(BURST_W), .NUM_CH(NUM_CH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .mode       (mode),
    .burst_len  (burst_len),
    .result_in  (result_in),
    .ch_sel     (ch_sel),
    .step_en    (step_en),
    .busy       (busy),
    .result_out (result_out)
`ifdef STEP_TRACE_EN
    ,.step_cnt  (step_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Tick and count step pulses seen after the edge.
  task automatic tickc();
    tick();
    if (step_en) pulses++;
  endtask

  initial begin
    // 1: reset holds everything low even with FREE and the button pressed
    mode = 2'b00; btn_raw = 1'b1; reset = 1'b0;
    repeat (5) tick();
    chk("rst_step_en", step_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result_out, 0);
    reset = 1'b1;
    tick();
    chk("rst_release_busy", busy, 1);
    chk("rst_release_step", step_en, 1);
    mode = 2'b11; btn_raw = 1'b0;
    repeat (15) tick();
    chk("halt_idle", busy, 0);

    // 2: single step, step_en exactly at edge k+7
    mode = 2'b01; result_in = 16'hA5A5; btn_raw = 1'b1;
    pulses = 0; first = -1;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 9) btn_raw = 1'b0;
      if (step_en) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    chk("single_edge", first, 7);
    chk("single_count", pulses, 1);
    ch_sel = 2'd0; #1;
    chk("single_hist0", result_out, 16'hA5A5);
    ch_sel = 2'd1; #1;
    chk("single_hist1", result_out, 0);
    repeat (12) tick();

    // 3: bouncing button never accepted
    mode = 2'b01; pulses = 0; busy_cnt = 0;
    for (int k = 0; k < 24; k++) begin
      btn_raw = (k < 12) ? ((k / 2) % 2 == 0) : 1'b0;
      tick();
      if (step_en) pulses++;
      if (busy) busy_cnt++;
    end
    chk("bounce_steps", pulses, 0);
    chk("bounce_busy", busy_cnt, 0);

    // 4: burst of 5 with result_in 1..5
    mode = 2'b10; burst_len = 8'd5; result_in = '0; btn_raw = 1'b1;
    i = 0;
    while (!step_en && i < 20) begin tick(); i++; end
    chk("burst_start", step_en, 1);
    pulses = 0; busy_cnt = 0;
    while (step_en && pulses < 10) begin
      pulses++;
      if (busy) busy_cnt++;
      result_in = DATA_W'(pulses);
      tick();
    end
    chk("burst_pulses", pulses, 5);
    chk("burst_busy_cycles", busy_cnt, 5);
    chk("burst_busy_end", busy, 0);
    for (int c = 0; c < 4; c++) begin
      ch_sel = 2'(c); #1;
      chk("burst_hist", result_out, 32'(5 - c));
    end
    btn_raw = 1'b0;
    repeat (12) tick();

    // 5: long burst aborted by HALT after 10 pulses; second press dropped
    reset = 1'b0; tick(); reset = 1'b1; tick();
    mode = 2'b10; burst_len = 8'd200; pulses = 0; btn_raw = 1'b1;
    repeat (4) tickc();
    btn_raw = 1'b0;
    repeat (5) tickc();
    btn_raw = 1'b1;
    i = 0;
    while (pulses < 10 && i < 40) begin tickc(); i++; end
    chk("abort_pulses", pulses, 10);
    chk("abort_busy_before", busy, 1);
    mode = 2'b11;
    tick();
    chk("abort_step_en", step_en, 0);
    chk("abort_busy", busy, 0);
`ifdef STEP_TRACE_EN
    chk("abort_step_cnt", step_cnt, 10);
`endif
    pulses = 0;
    repeat (5) tickc();
    mode = 2'b01;
    repeat (5) tickc();
    chk("abort_no_queue", pulses, 0);
    btn_raw = 1'b0;
    repeat (12) tick();

    // 6: free run for 20 cycles, then asynchronous reset mid-run
    mode = 2'b00; result_in = 16'h1234; ch_sel = 2'd0; pulses = 0;
    repeat (20) tickc();
    chk("free_pulses", pulses, 20);
    chk("free_hist0", result_out, 16'h1234);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_step_en", step_en, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_hist", result_out, 0);
    tick();
    reset = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
